// File: rtl/stage4_pkg.sv
// Shared pipeline types for the 8-bit datapath: widths, memory-stage control bundle, bubble value.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stage4_pkg;

    localparam int WORD_LENGTH    = 8;
    localparam int REG_ADDR_WIDTH = 3;

    // Control bits that travel with an instruction through the memory stage.
    typedef struct packed {
        logic memRead;
        logic memWrite;
        logic regWrite;
    } mem_ctrl_t;

    // All-zero control word: an instruction slot that has no side effects.
    localparam mem_ctrl_t BUBBLE = '0;

    // A result may be forwarded from EX/MEM only when it is already known, i.e. not a load.
    function automatic logic fwd_valid(input mem_ctrl_t ctrl);
        return ctrl.regWrite & ~ctrl.memRead;
    endfunction

endpackage

// File: rtl/stage4_data_memory.sv
// Data memory: synchronous write, asynchronous (combinational) read, contents never reset.
// Latency: write commits at the clock edge where we=1; read data follows addr in the same cycle.
// Backpressure: none; the caller suppresses we while the pipeline is stalled.
module stage4_data_memory #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WORD_LENGTH = 8,
    parameter int MEM_DEPTH   = 256
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [WORD_LENGTH-1:0] wdata,
    output logic [WORD_LENGTH-1:0] rdata
);

    logic [WORD_LENGTH-1:0] mem [MEM_DEPTH];

    // Store port: one word per enabled edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Load port is combinational so a load sees a store committed on the previous edge.
    assign rdata = mem[addr];

endmodule

// File: rtl/stage4.sv
// Memory/write-back stage: EX/MEM register, data memory, MEM/WB register, forwarding taps.
// Latency: inputs captured at edge N, memory access and MEM/WB load at N+1, regfile write at N+2.
// Backpressure: hold freezes EX/MEM, blocks the store and bubbles MEM/WB; flush bubbles EX/MEM.
module stage4
    import stage4_pkg::*;
#(
    parameter int WORD_LENGTH    = stage4_pkg::WORD_LENGTH,
    parameter int ADDR_WIDTH     = 8,
    parameter int MEM_DEPTH      = 256,
    parameter int REG_ADDR_WIDTH = stage4_pkg::REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WORD_LENGTH-1:0]    aluResult,
    input  logic [WORD_LENGTH-1:0]    storeData,
    input  logic [REG_ADDR_WIDTH-1:0] destReg,
    input  logic                      memReadIn,
    input  logic                      memWriteIn,
    input  logic                      regWriteIn,
    input  logic                      hold,
    input  logic                      flush,
    output logic [WORD_LENGTH-1:0]    exmemFwdData,
    output logic [REG_ADDR_WIDTH-1:0] exmemFwdReg,
    output logic                      exmemFwdValid,
    output logic [WORD_LENGTH-1:0]    wbData,
    output logic [REG_ADDR_WIDTH-1:0] wbReg,
    output logic                      wbEn
);

    mem_ctrl_t                 ctrl_in;
    mem_ctrl_t                 exmem_ctrl;
    logic [WORD_LENGTH-1:0]    exmem_alu;
    logic [WORD_LENGTH-1:0]    exmem_store;
    logic [REG_ADDR_WIDTH-1:0] exmem_dest;

    logic                      mem_we;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic [WORD_LENGTH-1:0]    mem_rdata;

    assign ctrl_in = '{memRead: memReadIn, memWrite: memWriteIn, regWrite: regWriteIn};

    // EX/MEM register: reset beats flush beats hold beats capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            exmem_ctrl  <= BUBBLE;
            exmem_alu   <= '0;
            exmem_store <= '0;
            exmem_dest  <= '0;
        end else if (flush) begin
            exmem_ctrl  <= BUBBLE;
            exmem_alu   <= '0;
            exmem_store <= '0;
            exmem_dest  <= '0;
        end else if (!hold) begin
            exmem_ctrl  <= ctrl_in;
            exmem_alu   <= aluResult;
            exmem_store <= storeData;
            exmem_dest  <= destReg;
        end
    end

    // A held store writes only on its release edge; a reset edge drops it entirely.
    assign mem_we   = exmem_ctrl.memWrite & ~hold & ~rst;
    assign mem_addr = exmem_alu[ADDR_WIDTH-1:0];

    stage4_data_memory #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .WORD_LENGTH (WORD_LENGTH),
        .MEM_DEPTH   (MEM_DEPTH)
    ) u_dmem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (exmem_store),
        .rdata (mem_rdata)
    );

    // MEM/WB register: a stalled cycle inserts a bubble so a held instruction retires once.
    always_ff @(posedge clk) begin
        if (rst || hold) begin
            wbData <= '0;
            wbReg  <= '0;
            wbEn   <= 1'b0;
        end else begin
            wbData <= exmem_ctrl.memRead ? mem_rdata : exmem_alu;
            wbReg  <= exmem_dest;
            wbEn   <= exmem_ctrl.regWrite;
        end
    end

    // Forwarding taps expose EX/MEM directly; load data is only available later via wb*.
    assign exmemFwdData  = exmem_alu;
    assign exmemFwdReg   = exmem_dest;
    assign exmemFwdValid = fwd_valid(exmem_ctrl);

endmodule

// File: tb/tb_stage4.sv
// Directed bench for stage4: reset, ALU write-back, store/load, hold, flush, reset mid-store.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: hold and flush are driven directly as directed stimulus.
module tb_stage4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] aluResult;
    logic [7:0] storeData;
    logic [2:0] destReg;
    logic       memReadIn;
    logic       memWriteIn;
    logic       regWriteIn;
    logic       hold;
    logic       flush;
    logic [7:0] exmemFwdData;
    logic [2:0] exmemFwdReg;
    logic       exmemFwdValid;
    logic [7:0] wbData;
    logic [2:0] wbReg;
    logic       wbEn;

    int n_pass  = 0;
    int n_total = 0;

    stage4 dut (
        .clk           (clk),
        .rst           (rst),
        .aluResult     (aluResult),
        .storeData     (storeData),
        .destReg       (destReg),
        .memReadIn     (memReadIn),
        .memWriteIn    (memWriteIn),
        .regWriteIn    (regWriteIn),
        .hold          (hold),
        .flush         (flush),
        .exmemFwdData  (exmemFwdData),
        .exmemFwdReg   (exmemFwdReg),
        .exmemFwdValid (exmemFwdValid),
        .wbData        (wbData),
        .wbReg         (wbReg),
        .wbEn          (wbEn)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] alu, input logic [7:0] sd, input logic [2:0] dr,
                         input logic rd, input logic wr, input logic rw);
        aluResult  = alu;
        storeData  = sd;
        destReg    = dr;
        memReadIn  = rd;
        memWriteIn = wr;
        regWriteIn = rw;
    endtask

    task automatic idle();
        drive(8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".wbData"},        wbData, 8'h00);
        check({tag, ".wbReg"},         {5'd0, wbReg}, 8'h00);
        check({tag, ".wbEn"},          {7'd0, wbEn}, 8'h00);
        check({tag, ".exmemFwdValid"}, {7'd0, exmemFwdValid}, 8'h00);
        check({tag, ".exmemFwdData"},  exmemFwdData, 8'h00);
        check({tag, ".exmemFwdReg"},   {5'd0, exmemFwdReg}, 8'h00);
    endtask

    initial begin
        // Reset held two cycles with nonzero inputs, including a store request.
        rst = 1'b1; hold = 1'b0; flush = 1'b0;
        drive(8'hFF, 8'h77, 3'd7, 1'b0, 1'b1, 1'b1);
        tick();
        tick();
        check_all_zero("reset");

        // ALU result write-back.
        rst = 1'b0;
        drive(8'h3C, 8'h00, 3'd5, 1'b0, 1'b0, 1'b1);
        tick();
        check("alu.fwdData",  exmemFwdData, 8'h3C);
        check("alu.fwdReg",   {5'd0, exmemFwdReg}, 8'h05);
        check("alu.fwdValid", {7'd0, exmemFwdValid}, 8'h01);
        check("alu.wbEn_early", {7'd0, wbEn}, 8'h00);
        idle();
        tick();
        check("alu.wbData", wbData, 8'h3C);
        check("alu.wbReg",  {5'd0, wbReg}, 8'h05);
        check("alu.wbEn",   {7'd0, wbEn}, 8'h01);
        check("alu.fwdValid_idle", {7'd0, exmemFwdValid}, 8'h00);

        // Store 0xA5 to 0x10, immediately followed by a load from 0x10 into r2.
        drive(8'h10, 8'hA5, 3'd0, 1'b0, 1'b1, 1'b0);
        tick();
        check("st.fwdValid", {7'd0, exmemFwdValid}, 8'h00);
        drive(8'h10, 8'h00, 3'd2, 1'b1, 1'b0, 1'b1);
        tick();
        check("ld.fwdValid", {7'd0, exmemFwdValid}, 8'h00);
        check("ld.fwdReg",   {5'd0, exmemFwdReg}, 8'h02);
        check("ld.fwdData",  exmemFwdData, 8'h10);
        check("st.wbEn",     {7'd0, wbEn}, 8'h00);
        idle();
        tick();
        check("ld.wbData", wbData, 8'hA5);
        check("ld.wbReg",  {5'd0, wbReg}, 8'h02);
        check("ld.wbEn",   {7'd0, wbEn}, 8'h01);

        // Store 0x11 to 0x20 held three cycles while the inputs change.
        drive(8'h20, 8'h11, 3'd0, 1'b0, 1'b1, 1'b0);
        tick();
        hold = 1'b1;
        drive(8'h55, 8'h99, 3'd6, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold.wbEn",    {7'd0, wbEn}, 8'h00);
            check("hold.fwdData", exmemFwdData, 8'h20);
        end
        hold = 1'b0;
        drive(8'h20, 8'h00, 3'd3, 1'b1, 1'b0, 1'b1);
        tick();
        idle();
        tick();
        check("hold.ld.wbData", wbData, 8'h11);
        check("hold.ld.wbReg",  {5'd0, wbReg}, 8'h03);
        check("hold.ld.wbEn",   {7'd0, wbEn}, 8'h01);

        // Held ALU instruction is written back exactly once after release.
        drive(8'h42, 8'h00, 3'd4, 1'b0, 1'b0, 1'b1);
        tick();
        hold = 1'b1;
        idle();
        tick();
        check("holdalu.wbEn_held", {7'd0, wbEn}, 8'h00);
        check("holdalu.fwdData",   exmemFwdData, 8'h42);
        hold = 1'b0;
        tick();
        check("holdalu.wbData", wbData, 8'h42);
        check("holdalu.wbReg",  {5'd0, wbReg}, 8'h04);
        check("holdalu.wbEn",   {7'd0, wbEn}, 8'h01);
        tick();
        check("holdalu.wbEn_once", {7'd0, wbEn}, 8'h00);

        // Flush turns a regWrite instruction into a bubble.
        flush = 1'b1;
        drive(8'h77, 8'h00, 3'd7, 1'b0, 1'b0, 1'b1);
        tick();
        check("flush.fwdValid", {7'd0, exmemFwdValid}, 8'h00);
        check("flush.fwdData",  exmemFwdData, 8'h00);
        flush = 1'b0;
        idle();
        tick();
        check("flush.wbEn", {7'd0, wbEn}, 8'h00);

        // Flush together with hold: the bubble replaces the held instruction.
        drive(8'h66, 8'h00, 3'd6, 1'b0, 1'b0, 1'b1);
        tick();
        check("fh.fwdValid_pre", {7'd0, exmemFwdValid}, 8'h01);
        flush = 1'b1;
        hold  = 1'b1;
        idle();
        tick();
        check("fh.fwdValid", {7'd0, exmemFwdValid}, 8'h00);
        check("fh.wbEn",     {7'd0, wbEn}, 8'h00);
        flush = 1'b0;
        hold  = 1'b0;
        tick();
        check("fh.wbEn_after", {7'd0, wbEn}, 8'h00);

        // Reset mid-store: 0x30 holds 0x5A, a store of 0xC3 is caught by reset.
        drive(8'h30, 8'h5A, 3'd0, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        drive(8'h30, 8'hC3, 3'd0, 1'b0, 1'b1, 1'b0);
        tick();
        rst = 1'b1;
        idle();
        tick();
        check_all_zero("rststore");
        rst = 1'b0;
        drive(8'h30, 8'h00, 3'd1, 1'b1, 1'b0, 1'b1);
        tick();
        idle();
        tick();
        check("rststore.ld.wbData", wbData, 8'h5A);
        check("rststore.ld.wbReg",  {5'd0, wbReg}, 8'h01);
        check("rststore.ld.wbEn",   {7'd0, wbEn}, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stage4.md
Name: stage4

Overview:
- Memory/write-back stage of the 8-bit pipelined datapath. It sits directly downstream of the execute stage and consumes that stage's ALU result, second register operand and control bits.
- Contains three pieces:
  - the EX/MEM pipeline register;
  - a synchronous-write / asynchronous-read data memory;
  - the MEM/WB pipeline register, which drives register-file write-back.
- Also exports forwarding taps back to execute and decode.

Parameters:
- WORD_LENGTH, 8, datapath width.
- ADDR_WIDTH, 8, data-memory address width.
- MEM_DEPTH, 256, data-memory words; must equal 2**ADDR_WIDTH.
- REG_ADDR_WIDTH, 3, register-file index width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- aluResult  in  WORD_LENGTH  execute-stage ALU output; used as memory address and as write-back data.
- storeData  in  WORD_LENGTH  r2 value from execute; data to store.
- destReg  in  REG_ADDR_WIDTH  destination register index.
- memReadIn  in  1  instruction is a load.
- memWriteIn  in  1  instruction is a store.
- regWriteIn  in  1  instruction writes the register file.
- hold  in  1  freeze EX/MEM (downstream stall).
- flush  in  1  load a bubble into EX/MEM.
- exmemFwdData  out  WORD_LENGTH  registered ALU result held in EX/MEM.
- exmemFwdReg  out  REG_ADDR_WIDTH  EX/MEM destination index.
- exmemFwdValid  out  1  EX/MEM regWrite & ~memRead.
- wbData  out  WORD_LENGTH  write-back value.
- wbReg  out  REG_ADDR_WIDTH  write-back destination index.
- wbEn  out  1  register-file write enable.

Behaviour:
- Reset (rst=1 at a rising edge):
  - all EX/MEM and MEM/WB fields go to 0; all outputs read 0 the cycle after.
  - data-memory contents are NOT reset.
  - reset overrides hold and flush.
  - reset mid-operation discards any in-flight store that has not yet written.
- EX/MEM update at each edge, in priority order rst > flush > hold > load:
  - flush=1: all control bits become 0 (bubble); data fields are don't-care and are driven to 0.
  - hold=1 and flush=0: all EX/MEM fields keep their value.
  - otherwise: capture all inputs.
- Data memory:
  - read is combinational: rdata = mem[EX/MEM.aluResult].
  - write occurs at the edge when EX/MEM.memWrite=1 and hold=0: mem[EX/MEM.aluResult] <= EX/MEM.storeData.
  - while held, the write is suppressed so a held store writes exactly once, on its release edge.
- MEM/WB update at each edge:
  - hold=1: capture a bubble (regWrite=0), so a held instruction is never written back twice.
  - otherwise:
    - wbData <= memRead ? rdata : aluResult.
    - wbReg <= destReg.
    - wbEn <= regWrite.
- Latency: inputs sampled at edge N → EX/MEM at N → store commits and MEM/WB loads at N+1 → wbData/wbEn valid during cycle N+1 → register file writes at edge N+2.
- Store followed immediately by a load to the same address: the store writes at edge N+1; the load reads during cycle N+1 and returns the new value. No bypass is required.
- memReadIn and memWriteIn both set is illegal; the result is unspecified and the bench must not drive it.
- Address width equals ADDR_WIDTH, so there is no out-of-range access. aluResult wider than ADDR_WIDTH uses its low bits.
- Forwarding taps:
  - exmemFwd* are direct copies of EX/MEM register contents; they are not gated by hold.
  - load results are forwarded only via wb*; exmemFwdValid is 0 for loads.

Decomposition:
- Shared package (e.g. cpu_pkg) holds:
  - WORD_LENGTH and REG_ADDR_WIDTH constants;
  - a mem_ctrl_t typedef {memRead, memWrite, regWrite};
  - a BUBBLE constant (all zeros) reused by the stage2/stage3 pipeline registers.
- One natural sub-module, data_memory: parameterized ADDR_WIDTH/WORD_LENGTH, ports clk, we, addr, wdata, rdata, asynchronous read.
- Pipeline registers stay inline in stage4.

Test Plan:
- Reset: assert rst for 2 cycles with nonzero inputs → wbData=0, wbReg=0, wbEn=0, exmemFwdValid=0.
- ALU write-back: aluResult=0x3C, destReg=5, regWriteIn=1 → one cycle later exmemFwdData=0x3C, exmemFwdValid=1; next cycle wbData=0x3C, wbReg=5, wbEn=1.
- Store then load: store storeData=0xA5 at aluResult=0x10, then in the next cycle load from 0x10 into destReg=2 → wbData=0xA5, wbReg=2, wbEn=1, exmemFwdValid=0 for the load.
- Hold: a store to 0x20 with data 0x11 is held 3 cycles while storeData changes to 0x99 → memory at 0x20 ends at 0x11, written once; wbEn=0 throughout the hold; one write-back after release.
- Flush: regWrite instruction with destReg=7 presented with flush=1 → exmemFwdValid=0 and wbEn=0; flush and hold together → bubble wins.
- Reset mid-store: store in EX/MEM with rst=1 at the next edge → target address retains its old value; all outputs are 0.
